// File: rtl/vram_arbiter_if.sv
// Bundle of VGA fetch, CPU data port and RAM port signals around the VRAM arbiter.
// slave = arbiter side, master = the clients/RAM side.
interface vram_arbiter_if #(
  parameter int AW    = 10,
  parameter int DW    = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_rdata;
  logic          vga_valid;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [CW-1:0] wfifo_count;

  modport slave (
    input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vga_rdata, vga_valid, cpu_ready, cpu_rdata, cpu_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata, wfifo_count
  );

  modport master (
    output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vga_rdata, vga_valid, cpu_ready, cpu_rdata, cpu_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata, wfifo_count
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA fetch has absolute priority, CPU writes are posted
// into a FIFO, CPU reads wait for an empty FIFO so read-after-write stays coherent.
module vram_arbiter #(
  parameter int AW    = 10,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input logic           dclk,
  input logic           clr,
  vram_arbiter_if.slave bus
);
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int PW     = $clog2(DEPTH);
  localparam int STAGES = 1;

  typedef enum logic [1:0] {R_IDLE, R_PEND, R_WAIT} rd_state_t;

  rd_state_t     state, state_nxt;
  logic [CW-1:0] cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] fifo_addr [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];
  logic [AW-1:0] rd_addr;
  logic [STAGES:0] vld_pipe;
  logic gnt_vga, gnt_rd, gnt_wr;
  logic push, pop, rd_accept, rd_issue, rd_capture;

  // Grant is gated by clr so the RAM port is quiet while reset is held.
  assign gnt_vga = bus.vga_req & ~clr;
  assign gnt_rd  = rd_issue & ~bus.vga_req & ~clr;
  assign gnt_wr  = ~rd_issue & ~bus.vga_req & ~clr & (cnt != '0);

  // Write readiness uses the registered count: a same-cycle pop never unblocks a full FIFO.
  assign bus.cpu_ready = ~clr & (bus.cpu_we ? (cnt < CW'(DEPTH))
                                            : (state == R_IDLE && cnt == '0));
  assign push      = bus.cpu_req & bus.cpu_we & bus.cpu_ready;
  assign rd_accept = bus.cpu_req & ~bus.cpu_we & bus.cpu_ready;
  assign pop       = gnt_wr;
  assign bus.wfifo_count = cnt;

  always_comb begin
    bus.mem_en    = gnt_vga | gnt_rd | gnt_wr;
    bus.mem_we    = gnt_wr;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt_vga) begin
      bus.mem_addr = bus.vga_addr;
    end else if (gnt_rd) begin
      bus.mem_addr = rd_addr;
    end else if (gnt_wr) begin
      bus.mem_addr  = fifo_addr[rd_ptr];
      bus.mem_wdata = fifo_data[rd_ptr];
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge dclk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.cpu_addr;
      fifo_data[wr_ptr] <= bus.cpu_wdata;
    end
  end

  // Read FSM: state register
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) state <= R_IDLE;
    else     state <= state_nxt;
  end

  // Read FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      R_IDLE:  if (rd_accept) state_nxt = R_PEND;
      R_PEND:  if (gnt_rd)    state_nxt = R_WAIT;
      R_WAIT:                 state_nxt = R_IDLE;
      default:                state_nxt = R_IDLE;
    endcase
  end

  // Read FSM: outputs
  always_comb begin
    rd_issue   = (state == R_PEND);
    rd_capture = (state == R_WAIT);
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      rd_addr        <= '0;
      vld_pipe       <= '0;
      bus.vga_rdata  <= '0;
      bus.cpu_rvalid <= 1'b0;
      bus.cpu_rdata  <= '0;
    end else begin
      if (rd_accept) rd_addr <= bus.cpu_addr;
      vld_pipe <= {vld_pipe[STAGES-1:0], gnt_vga};
      if (vld_pipe[0]) bus.vga_rdata <= bus.mem_rdata;
      bus.cpu_rvalid <= rd_capture;
      if (rd_capture) bus.cpu_rdata <= bus.mem_rdata;
    end
  end

  assign bus.vga_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM and write log.
module tb_vram_arbiter;
  localparam int AW = 10, DW = 32, DEPTH = 4;

  logic dclk = 1'b0;
  logic clr;
  always #5 dclk = ~dclk;

  vram_arbiter_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();
  vram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (.dclk(dclk), .clr(clr), .bus(bus));

  logic [DW-1:0] ram [1024];
  int cyc = 0;
  int wl_addr[$];
  int wl_cyc[$];
  logic [DW-1:0] wl_data[$];

  always @(posedge dclk) begin
    cyc <= cyc + 1;
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr] <= bus.mem_wdata;
        wl_addr.push_back(int'(bus.mem_addr));
        wl_data.push_back(bus.mem_wdata);
        wl_cyc.push_back(cyc);
      end else begin
        bus.mem_rdata <= ram[bus.mem_addr];
      end
    end
  end

  int total = 0, passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  // Counts edges until cpu_rvalid is seen, bounded by lim.
  task automatic wait_rv(input int lim, output int n);
    n = 0;
    do begin tick(); n++; end while (!bus.cpu_rvalid && n < lim);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } vga_vec_t;
  vga_vec_t vv[5];

  initial begin
    int n, rv_seen;
    for (int i = 0; i < 1024; i++) ram[i] = DW'(i) + 32'h100;
    for (int i = 0; i < 5; i++) begin
      vv[i].addr = AW'(10'h28 + i);
      vv[i].exp  = 32'h128 + DW'(i);
    end

    // Reset: outputs quiet even with requests present
    clr = 1'b1;
    bus.vga_req = 1'b1; bus.vga_addr = 10'h5;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    #2;
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_cpu_ready", bus.cpu_ready, 0);
    chk("rst_vga_valid", bus.vga_valid, 0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_vga_rdata", bus.vga_rdata, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_count", bus.wfifo_count, 0);
    bus.vga_req = 1'b0; bus.cpu_req = 1'b0;
    tick(); tick();
    clr = 1'b0;
    #1;
    chk("post_rst_ready_wr", bus.cpu_ready, 1);
    bus.cpu_we = 1'b0; #1;
    chk("post_rst_ready_rd", bus.cpu_ready, 1);
    chk("post_rst_count", bus.wfifo_count, 0);
    tick();

    // VGA burst from the vector table
    for (int i = 0; i < 7; i++) begin
      bus.vga_req  = (i < 5);
      bus.vga_addr = (i < 5) ? vv[i].addr : '0;
      tick();
      chk($sformatf("vga_valid_%0d", i), bus.vga_valid, (i >= 1 && i <= 5));
      if (i >= 1 && i <= 5) chk($sformatf("vga_rdata_%0d", i), bus.vga_rdata, vv[i-1].exp);
    end
    chk("vga_rdata_hold", bus.vga_rdata, vv[4].exp);

    // FIFO fills while VGA owns the port
    wl_addr.delete(); wl_data.delete(); wl_cyc.delete();
    bus.vga_req = 1'b1; bus.vga_addr = 10'h0;
    for (int i = 0; i < 5; i++) begin
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
      bus.cpu_addr = AW'(10'h10 + i); bus.cpu_wdata = 32'hA0 + DW'(i);
      #1;
      chk($sformatf("full_ready_%0d", i), bus.cpu_ready, (i < 4));
      chk($sformatf("full_head_held_%0d", i), bus.mem_we, 0);
      tick();
    end
    chk("full_count", bus.wfifo_count, 4);
    bus.vga_req = 1'b0; #1;
    chk("drain_ready_c1", bus.cpu_ready, 0);
    chk("drain_head_addr", bus.mem_addr, 10'h10);
    chk("drain_head_data", bus.mem_wdata, 32'hA0);
    tick();
    chk("drain_ready_c2", bus.cpu_ready, 1);
    tick();
    bus.cpu_req = 1'b0;
    repeat (3) tick();
    chk("drain_count", bus.wfifo_count, 0);
    chk("drain_nwrites", wl_addr.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < wl_addr.size()) begin
        chk($sformatf("drain_addr_%0d", i), wl_addr[i], 10'h10 + i);
        chk($sformatf("drain_data_%0d", i), wl_data[i], 32'hA0 + i);
        chk($sformatf("drain_cyc_%0d", i), wl_cyc[i] - wl_cyc[0], i);
      end
    end

    // Read-after-write to the same address
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'h20; bus.cpu_wdata = 32'hDEADBEEF;
    tick();
    bus.cpu_we = 1'b0; #1;
    chk("raw_rd_blocked", bus.cpu_ready, 0);
    chk("raw_count", bus.wfifo_count, 1);
    tick();
    chk("raw_rd_ready", bus.cpu_ready, 1);
    tick();
    bus.cpu_req = 1'b0;
    wait_rv(10, n);
    chk("raw_latency", n, 2);
    chk("raw_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    tick();
    chk("raw_rvalid_pulse", bus.cpu_rvalid, 0);
    chk("raw_rdata_hold", bus.cpu_rdata, 32'hDEADBEEF);

    // Read blocked by 3 VGA cycles
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h33;
    tick();
    bus.cpu_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.vga_req = 1'b1; bus.vga_addr = AW'(10'h40 + k); #1;
      chk($sformatf("cont_vga_wins_%0d", k), bus.mem_addr, 10'h40 + k);
      tick();
      chk($sformatf("cont_rvalid_%0d", k), bus.cpu_rvalid, 0);
      if (k > 0) chk($sformatf("cont_vga_data_%0d", k), bus.vga_rdata, 32'h140 + k - 1);
    end
    bus.vga_req = 1'b0; #1;
    chk("cont_rd_addr", bus.mem_addr, 10'h33);
    chk("cont_rd_we", bus.mem_we, 0);
    wait_rv(10, n);
    chk("cont_latency", n + 3, 5);
    chk("cont_rdata", bus.cpu_rdata, 32'h133);

    // clr while a read is pending and a write is queued
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h50;
    bus.vga_req = 1'b1; bus.vga_addr = 10'h7;
    tick();
    bus.cpu_we = 1'b1; bus.cpu_addr = 10'h60; bus.cpu_wdata = 32'h55;
    tick();
    bus.cpu_req = 1'b0;
    chk("prst_count", bus.wfifo_count, 1);
    chk("prst_vga_inflight", bus.vga_valid, 1);
    clr = 1'b1; #1;
    chk("prst_count_clr", bus.wfifo_count, 0);
    chk("prst_vga_valid", bus.vga_valid, 0);
    chk("prst_mem_en", bus.mem_en, 0);
    tick();
    clr = 1'b0; bus.vga_req = 1'b0;
    wl_addr.delete(); wl_data.delete(); wl_cyc.delete();
    rv_seen = 0;
    for (int k = 0; k < 6; k++) begin tick(); rv_seen += int'(bus.cpu_rvalid); end
    chk("prst_no_rvalid", rv_seen, 0);
    chk("prst_no_write", wl_addr.size(), 0);
    chk("prst_ram_60", ram[10'h60], 32'h160);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h51;
    tick();
    bus.cpu_req = 1'b0;
    wait_rv(10, n);
    chk("prst_next_latency", n, 2);
    chk("prst_next_rdata", bus.cpu_rdata, 32'h151);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
